// File: rtl/beat_seq_pkg.sv
// beat_seq_pkg: shared constants for the beat sequencer slice.
//   IDLE/RUN/PAUSE : 2-bit state encoding, exposed on the `state` port.
//   MIN_PERIOD     : smallest accepted beat period, in clk cycles.
//   SUB_IDX_W      : width of the quarter-beat index.
package beat_seq_pkg;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] RUN   = 2'b01;
  localparam logic [1:0] PAUSE = 2'b10;

  localparam int unsigned MIN_PERIOD = 4;
  localparam int unsigned SUB_IDX_W  = 2;

endpackage

// File: rtl/beat_divider.sv
// beat_divider: phase counter and tick generator for one beat.
//   clk, rst_n    : clock, asynchronous active-low reset
//   enable_i      : advance the phase this cycle (sequencer heading into RUN)
//   clear_i       : return phase, usr_clk and ticks to 0
//   period_i      : beat period P in cycles (>= 4)
//   quarter_i     : Q = P >> 2
//   beat_due_o    : combinational, a beat tick is being registered this cycle
//   beat_tick_o   : registered pulse, beat start
//   sub_tick_o    : registered pulse, quarter-beat start
//   sub_idx_o     : quarter index of the most recent sub tick
//   usr_clk_o     : high while the phase is in the first half of the beat
module beat_divider
  import beat_seq_pkg::*;
#(
  parameter int unsigned CNT_W = 25
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable_i,
  input  logic                 clear_i,
  input  logic [CNT_W-1:0]     period_i,
  input  logic [CNT_W-1:0]     quarter_i,
  output logic                 beat_due_o,
  output logic                 beat_tick_o,
  output logic                 sub_tick_o,
  output logic [SUB_IDX_W-1:0] sub_idx_o,
  output logic                 usr_clk_o
);

  logic [CNT_W-1:0]     phase_q, phase_d;
  logic                 beat_tick_q, beat_tick_d;
  logic                 sub_tick_q, sub_tick_d;
  logic [SUB_IDX_W-1:0] sub_idx_q, sub_idx_d;
  logic                 usr_clk_q, usr_clk_d;

  logic [CNT_W-1:0]     half;
  logic [CNT_W-1:0]     three_q;
  logic                 hit;
  logic [SUB_IDX_W-1:0] hit_idx;

  assign half    = quarter_i << 1;
  assign three_q = half + quarter_i;

  // Quarter boundaries are distinct because P >= 4 guarantees Q >= 1;
  // the last quarter absorbs the P - 3Q remainder.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    if (phase_q == '0) begin
      hit     = 1'b1;
      hit_idx = SUB_IDX_W'(0);
    end else if (phase_q == quarter_i) begin
      hit     = 1'b1;
      hit_idx = SUB_IDX_W'(1);
    end else if (phase_q == half) begin
      hit     = 1'b1;
      hit_idx = SUB_IDX_W'(2);
    end else if (phase_q == three_q) begin
      hit     = 1'b1;
      hit_idx = SUB_IDX_W'(3);
    end
  end

  // Outputs reflect the phase held during the cycle that just ended, so a
  // tick for phase 0 appears one cycle after the enabling edge is seen.
  always_comb begin
    phase_d     = phase_q;
    beat_tick_d = 1'b0;
    sub_tick_d  = 1'b0;
    sub_idx_d   = sub_idx_q;
    usr_clk_d   = usr_clk_q;
    if (clear_i) begin
      phase_d   = '0;
      usr_clk_d = 1'b0;
    end else if (enable_i) begin
      phase_d     = (phase_q == period_i - CNT_W'(1)) ? '0 : phase_q + CNT_W'(1);
      sub_tick_d  = hit;
      beat_tick_d = (phase_q == '0);
      if (hit) begin
        sub_idx_d = hit_idx;
      end
      usr_clk_d = (phase_q < half);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q     <= '0;
      beat_tick_q <= 1'b0;
      sub_tick_q  <= 1'b0;
      sub_idx_q   <= '0;
      usr_clk_q   <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      beat_tick_q <= beat_tick_d;
      sub_tick_q  <= sub_tick_d;
      sub_idx_q   <= sub_idx_d;
      usr_clk_q   <= usr_clk_d;
    end
  end

  assign beat_due_o  = enable_i && !clear_i && (phase_q == '0);
  assign beat_tick_o = beat_tick_q;
  assign sub_tick_o  = sub_tick_q;
  assign sub_idx_o   = sub_idx_q;
  assign usr_clk_o   = usr_clk_q;

endmodule

// File: rtl/beat_sequencer.sv
// beat_sequencer: start/pause/stop sequenced timebase with programmable
// beat period, beat/quarter strobes, a half-duty user clock and beat/bar
// position counters.
//   clk, reset   : clock, asynchronous active-low reset
//   start/pause/stop : commands, priority stop > pause > start
//   cfg_we, cfg_period : period write, accepted only in IDLE (min 4)
//   cfg_err      : pulse one cycle after a rejected cfg_we
//   state        : 00 IDLE, 01 RUN, 10 PAUSE
//   beat_tick, sub_tick, sub_idx, usr_clk : timing outputs
//   beat_idx, bar_count : position within bar / completed bars
// Optional: define BEAT_SEQ_BAR_IRQ_EN to add bar_irq (sticky, set on every
// bar_count increment) and irq_ack (clears it; a simultaneous set wins).
module beat_sequencer
  import beat_seq_pkg::*;
#(
  parameter  int unsigned CNT_W          = 25,
  parameter  int unsigned DEFAULT_PERIOD = 25000000,
  parameter  int unsigned BEATS_PER_BAR  = 4,
  parameter  int unsigned BAR_W          = 8,
  localparam int unsigned BI_W           = (BEATS_PER_BAR > 1) ? $clog2(BEATS_PER_BAR) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef BEAT_SEQ_BAR_IRQ_EN
  input  logic                 irq_ack,
  output logic                 bar_irq,
`endif
  input  logic                 start,
  input  logic                 pause,
  input  logic                 stop,
  input  logic                 cfg_we,
  input  logic [CNT_W-1:0]     cfg_period,
  output logic                 cfg_err,
  output logic [1:0]           state,
  output logic                 beat_tick,
  output logic                 sub_tick,
  output logic [SUB_IDX_W-1:0] sub_idx,
  output logic                 usr_clk,
  output logic [BI_W-1:0]      beat_idx,
  output logic [BAR_W-1:0]     bar_count
);

  localparam logic [CNT_W-1:0] MIN_P    = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] RST_P    = CNT_W'(DEFAULT_PERIOD);
  localparam logic [BI_W-1:0]  LAST_IDX = BI_W'(BEATS_PER_BAR - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] quarter_q, quarter_d;
  logic             cfg_err_q, cfg_err_d;
  logic [BI_W-1:0]  beat_idx_q, beat_idx_d;
  logic [BAR_W-1:0] bar_q, bar_d;
  logic             started_q, started_d;

  logic             enable;
  logic             clear;
  logic             beat_due;

  // Command decode; pause in IDLE and start while already running are no-ops.
  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = IDLE;
    end else if (pause) begin
      if (state_q == RUN) begin
        state_d = PAUSE;
      end
    end else if (start) begin
      if (state_q != RUN) begin
        state_d = RUN;
      end
    end
  end

  // Driving the divider from the next state gives the one-cycle start latency
  // and suppresses any tick in the cycle a stop or pause is taken.
  assign enable = (state_d == RUN);
  assign clear  = (state_d == IDLE);

  always_comb begin
    period_d  = period_q;
    quarter_d = quarter_q;
    cfg_err_d = 1'b0;
    if (cfg_we) begin
      if (state_q == IDLE) begin
        period_d  = (cfg_period < MIN_P) ? MIN_P : cfg_period;
        quarter_d = period_d >> 2;
      end else begin
        cfg_err_d = 1'b1;
      end
    end
  end

  // started_q marks that the first beat of this run has been emitted; that
  // beat is position 0 and does not advance the counters.
  always_comb begin
    beat_idx_d = beat_idx_q;
    bar_d      = bar_q;
    started_d  = started_q;
    if (clear) begin
      beat_idx_d = '0;
      bar_d      = '0;
      started_d  = 1'b0;
    end else if (beat_due) begin
      started_d = 1'b1;
      if (started_q) begin
        if (beat_idx_q == LAST_IDX) begin
          beat_idx_d = '0;
          bar_d      = bar_q + BAR_W'(1);
        end else begin
          beat_idx_d = beat_idx_q + BI_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      period_q   <= RST_P;
      quarter_q  <= RST_P >> 2;
      cfg_err_q  <= 1'b0;
      beat_idx_q <= '0;
      bar_q      <= '0;
      started_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      period_q   <= period_d;
      quarter_q  <= quarter_d;
      cfg_err_q  <= cfg_err_d;
      beat_idx_q <= beat_idx_d;
      bar_q      <= bar_d;
      started_q  <= started_d;
    end
  end

  beat_divider #(
    .CNT_W (CNT_W)
  ) u_div (
    .clk         (clk),
    .rst_n       (reset),
    .enable_i    (enable),
    .clear_i     (clear),
    .period_i    (period_q),
    .quarter_i   (quarter_q),
    .beat_due_o  (beat_due),
    .beat_tick_o (beat_tick),
    .sub_tick_o  (sub_tick),
    .sub_idx_o   (sub_idx),
    .usr_clk_o   (usr_clk)
  );

`ifdef BEAT_SEQ_BAR_IRQ_EN
  logic bar_irq_q, bar_irq_d;
  logic bar_wrap;

  assign bar_wrap = !clear && beat_due && started_q && (beat_idx_q == LAST_IDX);

  always_comb begin
    bar_irq_d = bar_irq_q;
    if (stop) begin
      bar_irq_d = 1'b0;
    end else if (bar_wrap) begin
      bar_irq_d = 1'b1;
    end else if (irq_ack) begin
      bar_irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bar_irq_q <= 1'b0;
    end else begin
      bar_irq_q <= bar_irq_d;
    end
  end

  assign bar_irq = bar_irq_q;
`endif

  assign state     = state_q;
  assign cfg_err   = cfg_err_q;
  assign beat_idx  = beat_idx_q;
  assign bar_count = bar_q;

endmodule

// File: tb/tb_beat_sequencer.sv
module tb_beat_sequencer;

  localparam int unsigned CNT_W          = 25;
  localparam int unsigned DEFAULT_PERIOD = 25000000;
  localparam int unsigned BPB            = 4;
  localparam int unsigned BAR_W          = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0, pause = 1'b0, stop = 1'b0;
  logic             cfg_we = 1'b0;
  logic [CNT_W-1:0] cfg_period = '0;
  logic             irq_ack = 1'b0;
  logic             cfg_err;
  logic [1:0]       state;
  logic             beat_tick, sub_tick, usr_clk;
  logic [1:0]       sub_idx;
  logic [1:0]       beat_idx;
  logic [BAR_W-1:0] bar_count;
`ifdef BEAT_SEQ_BAR_IRQ_EN
  logic             bar_irq;
`endif

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: position derived from the count of run cycles.
  int unsigned m_state, m_P, rc;
  int unsigned e_beat, e_sub, e_subidx, e_usr, e_bidx, e_bar, e_err, e_irq;

  beat_sequencer #(
    .CNT_W          (CNT_W),
    .DEFAULT_PERIOD (DEFAULT_PERIOD),
    .BEATS_PER_BAR  (BPB),
    .BAR_W          (BAR_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef BEAT_SEQ_BAR_IRQ_EN
    .irq_ack    (irq_ack),
    .bar_irq    (bar_irq),
`endif
    .start      (start),
    .pause      (pause),
    .stop       (stop),
    .cfg_we     (cfg_we),
    .cfg_period (cfg_period),
    .cfg_err    (cfg_err),
    .state      (state),
    .beat_tick  (beat_tick),
    .sub_tick   (sub_tick),
    .sub_idx    (sub_idx),
    .usr_clk    (usr_clk),
    .beat_idx   (beat_idx),
    .bar_count  (bar_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_P = DEFAULT_PERIOD; rc = 0;
    e_beat = 0; e_sub = 0; e_subidx = 0; e_usr = 0;
    e_bidx = 0; e_bar = 0; e_err = 0; e_irq = 0;
  endtask

  task automatic model_edge();
    int unsigned nxt, ph, q, beats;
    bit          bar_set;
    bar_set = 0;
    e_err   = (cfg_we && m_state != 0) ? 1 : 0;
    if (m_state == 0 && cfg_we) m_P = (cfg_period < 4) ? 4 : int'(cfg_period);
    nxt = m_state;
    if (stop) nxt = 0;
    else if (pause) begin
      if (m_state == 1) nxt = 2;
    end else if (start) begin
      if (m_state != 1) nxt = 1;
    end
    e_beat = 0; e_sub = 0;
    if (nxt == 0) begin
      rc = 0; e_usr = 0; e_bidx = 0; e_bar = 0;
    end else if (nxt == 1) begin
      q  = m_P / 4;
      ph = rc % m_P;
      if (ph == 0 || ph == q || ph == 2*q || ph == 3*q) begin
        e_sub = 1; e_subidx = ph / q;
      end
      e_usr = (ph < 2*q) ? 1 : 0;
      if (ph == 0) begin
        e_beat = 1;
        beats  = rc / m_P;
        e_bidx = beats % BPB;
        e_bar  = (beats / BPB) % 256;
        if (beats > 0 && beats % BPB == 0) bar_set = 1;
      end
      rc++;
    end
    if (stop) e_irq = 0;
    else if (bar_set) e_irq = 1;
    else if (irq_ack) e_irq = 0;
    m_state = nxt;
  endtask

  task automatic compare_all();
    check("state", state, m_state);
    check("beat_tick", beat_tick, e_beat);
    check("sub_tick", sub_tick, e_sub);
    check("sub_idx", sub_idx, e_subidx);
    check("usr_clk", usr_clk, e_usr);
    check("beat_idx", beat_idx, e_bidx);
    check("bar_count", bar_count, e_bar);
    check("cfg_err", cfg_err, e_err);
`ifdef BEAT_SEQ_BAR_IRQ_EN
    check("bar_irq", bar_irq, e_irq);
`endif
  endtask

  // Apply inputs just after an edge, then advance one clock and compare.
  task automatic cyc(input logic st, input logic pa, input logic sp,
                     input logic we, input int unsigned per, input logic ack);
    start = st; pause = pa; stop = sp; cfg_we = we;
    cfg_period = CNT_W'(per); irq_ack = ack;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle_cyc();
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic restart(input int unsigned per);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, per, 0);
    cyc(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned cnt, k, r;
    bit          seen255, wrapped;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    reset = 1'b1;

    // P=16: beat every 16, quarter every 4, usr_clk 8 high / 8 low.
    restart(16);
    check("t16_first_beat", beat_tick, 1);
    check("t16_first_sub", sub_tick, 1);
    for (int i = 2; i <= 40; i++) begin
      idle_cyc();
      check("t16_beat", beat_tick, ((i-1) % 16 == 0) ? 1 : 0);
      check("t16_sub", sub_tick, ((i-1) % 4 == 0) ? 1 : 0);
      check("t16_usr", usr_clk, ((i-1) % 16 < 8) ? 1 : 0);
      if ((i-1) % 4 == 0) check("t16_idx", sub_idx, ((i-1) % 16) / 4);
    end

    // cfg_period=2 clamps to 4.
    restart(2);
    for (int i = 1; i <= 12; i++) begin
      if (i > 1) idle_cyc();
      check("p4_sub", sub_tick, 1);
      check("p4_beat", beat_tick, ((i-1) % 4 == 0) ? 1 : 0);
      check("p4_idx", sub_idx, (i-1) % 4);
    end

    // Pause at phase 6, hold 20 cycles, resume.
    restart(16);
    repeat (5) idle_cyc();
    cyc(0, 1, 0, 0, 0, 0);
    check("pause_state", state, 2);
    for (int i = 0; i < 20; i++) begin
      cyc(0, (i % 3 == 0) ? 1'b1 : 1'b0, 0, 0, 0, 0);
      check("pause_nosub", sub_tick, 0);
    end
    cyc(1, 0, 0, 0, 0, 0);
    check("resume_nosub", sub_tick, 0);
    idle_cyc();
    check("resume_nosub2", sub_tick, 0);
    idle_cyc();
    check("resume_sub", sub_tick, 1);
    check("resume_idx", sub_idx, 2);

    // cfg_we while running is rejected.
    cyc(0, 0, 0, 1, 5, 0);
    check("cfg_err_pulse", cfg_err, 1);
    idle_cyc();
    check("cfg_err_clear", cfg_err, 0);
    repeat (40) idle_cyc();

    // stop and pause together -> IDLE, counters cleared.
    cyc(0, 1, 1, 0, 0, 0);
    check("stoppause_state", state, 0);
    check("stoppause_bar", bar_count, 0);
    check("stoppause_usr", usr_clk, 0);

    // P=8, 40 beats.
    restart(8);
    cnt = 1; k = 0;
    while (cnt < 40 && k < 400) begin
      idle_cyc();
      if (beat_tick) cnt++;
      k++;
    end
    check("b40_reached", cnt, 40);
    check("b40_bar", bar_count, 9);
    check("b40_idx", beat_idx, 3);

    // bar_count wrap 255 -> 0 at P=4.
    restart(4);
    seen255 = 0; wrapped = 0; k = 0;
    while (!wrapped && k < 4300) begin
      idle_cyc();
      if (bar_count == 255) seen255 = 1;
      else if (seen255 && bar_count == 0) wrapped = 1;
      k++;
    end
    check("wrap_seen255", seen255, 1);
    check("wrap_done", wrapped, 1);

`ifdef BEAT_SEQ_BAR_IRQ_EN
    // First bar wrap at rc=16 sets irq; ack on the wrap at rc=32 loses.
    restart(4);
    while (rc < 40) begin
      r = rc;
      cyc(0, 0, 0, 0, 0, (r == 32 || r == 36) ? 1'b1 : 1'b0);
      if (r == 16) check("irq_set", bar_irq, 1);
      if (r == 32) check("irq_ack_vs_set", bar_irq, 1);
      if (r == 36) check("irq_lone_ack", bar_irq, 0);
    end
`endif

    // Reset asserted mid-run clears outputs without a clock edge.
    restart(8);
    repeat (13) idle_cyc();
    #2 reset = 1'b0;
    #1;
    check("arst_state", state, 0);
    check("arst_beat", beat_tick, 0);
    check("arst_sub", sub_tick, 0);
    check("arst_idx", sub_idx, 0);
    check("arst_usr", usr_clk, 0);
    check("arst_bidx", beat_idx, 0);
    check("arst_bar", bar_count, 0);
    check("arst_err", cfg_err, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_cyc();

    // Randomized commands against the model.
    for (int i = 0; i < 3000; i++) begin
      logic st, pa, sp, we, ack;
      r   = $urandom_range(0, 99);
      st  = (r < 20);
      pa  = (r >= 20 && r < 26) || ($urandom_range(0, 99) < 3);
      sp  = (r >= 26 && r < 29);
      we  = ($urandom_range(0, 99) < 8);
      ack = ($urandom_range(0, 99) < 10);
      cyc(st, pa, sp, we, $urandom_range(0, 24), ack);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
